change_dispenser: RTL and testbench

//  Downstream of the vending selection FSM. On a start strobe it takes the change amount owed, in cents,
//  and pays it out as individual coin requests to a coin hopper over a valid/ack handshake.

---
 rtl/vending_pkg.sv | 37 +++
 rtl/change_coin_picker.sv | 24 ++
 rtl/change_dispenser.sv | 149 ++++++++++++++
 tb/tb_change_dispenser.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine change path: denomination
// indices, their cent values and the change dispenser state encoding.
package vending_pkg;

    localparam int NUM_DENOM = 6;

    localparam logic [2:0] DENOM_500 = 3'd0;
    localparam logic [2:0] DENOM_100 = 3'd1;
    localparam logic [2:0] DENOM_25  = 3'd2;
    localparam logic [2:0] DENOM_10  = 3'd3;
    localparam logic [2:0] DENOM_5   = 3'd4;
    localparam logic [2:0] DENOM_1   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT_ACK,
        ST_DONE
    } disp_state_t;

    // Cent value of a denomination index; unused codes map to 0 so they can
    // never be chosen as a coin that pays anything.
    function automatic logic [15:0] coin_value(input logic [2:0] idx);
        logic [15:0] val;
        case (idx)
            DENOM_500: val = 16'd500;
            DENOM_100: val = 16'd100;
            DENOM_25:  val = 16'd25;
            DENOM_10:  val = 16'd10;
            DENOM_5:   val = 16'd5;
            DENOM_1:   val = 16'd1;
            default:   val = 16'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/change_coin_picker.sv
// Greedy coin picker: finds the largest usable coin (lowest index) whose
// value still fits into the amount left to pay.
import vending_pkg::*;

module change_coin_picker (
    input  logic [15:0] remaining_i,
    input  logic [5:0]  blocked_i,
    output logic        found_o,
    output logic [2:0]  index_o
);

    // Scan from the smallest coin upwards so the last hit (lowest index) wins.
    always_comb begin
        found_o = 1'b0;
        index_o = 3'd0;
        for (int d = NUM_DENOM - 1; d >= 0; d--) begin
            if (!blocked_i[d] && (coin_value(3'(d)) <= remaining_i)) begin
                found_o = 1'b1;
                index_o = 3'(d);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an owed amount as individual coin requests to
// the hopper, largest coin first, skipping empty tubes and tubes that have
// timed out on a request.
import vending_pkg::*;

module change_dispenser #(
    parameter int P_ACK_TIMEOUT = 1000,
    parameter int P_CNT_W       = 8
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               I_START,
    input  logic [15:0]        I_AMOUNT,
    input  logic [5:0]         I_EMPTY,
    input  logic               I_COIN_ACK,
    output logic               O_COIN_VALID,
    output logic [2:0]         O_COIN_SEL,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic [15:0]        O_SHORT,
    output logic [P_CNT_W-1:0] O_COINS,
    output logic [5:0]         O_FAULT
);

    localparam int               TMR_W    = $clog2(P_ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(P_ACK_TIMEOUT - 1);

    disp_state_t        state_q, state_d;
    logic [15:0]        remaining_q, remaining_d;
    logic [15:0]        short_q, short_d;
    logic [P_CNT_W-1:0] coins_q, coins_d;
    logic [5:0]         fault_q, fault_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [2:0]         sel_q, sel_d;

    logic               pickFound;
    logic [2:0]         pickIndex;
    logic [15:0]        ackRemaining;

    change_coin_picker u_picker (
        .remaining_i (remaining_q),
        .blocked_i   (I_EMPTY | fault_q),
        .found_o     (pickFound),
        .index_o     (pickIndex)
    );

    assign ackRemaining = remaining_q - coin_value(sel_q);

    // Next-state logic: the short amount is captured on entry to DONE so it
    // is already valid during the single DONE cycle that drives O_DONE.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        short_d     = short_q;
        coins_d     = coins_q;
        fault_d     = fault_q;
        timer_d     = timer_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        sel_d       = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (I_START) begin
                    remaining_d = I_AMOUNT;
                    coins_d     = '0;
                    short_d     = 16'd0;
                    busy_d      = 1'b1;
                    state_d     = (I_AMOUNT == 16'd0) ? ST_DONE : ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (pickFound) begin
                    sel_d   = pickIndex;
                    valid_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_WAIT_ACK;
                end else begin
                    short_d = remaining_q;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_ACK: begin
                if (I_COIN_ACK && valid_q) begin
                    remaining_d = ackRemaining;
                    valid_d     = 1'b0;
                    if (coins_q != {P_CNT_W{1'b1}}) begin
                        coins_d = coins_q + 1'b1;
                    end
                    if (ackRemaining == 16'd0) begin
                        short_d = 16'd0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SELECT;
                    end
                end else if (timer_q == TMR_LAST) begin
                    fault_d = fault_q | (6'b000001 << sel_q);
                    valid_d = 1'b0;
                    state_d = ST_SELECT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DONE: begin
                short_d = remaining_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q     <= ST_IDLE;
            remaining_q <= 16'd0;
            short_q     <= 16'd0;
            coins_q     <= '0;
            fault_q     <= 6'd0;
            timer_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            sel_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            short_q     <= short_d;
            coins_q     <= coins_d;
            fault_q     <= fault_d;
            timer_q     <= timer_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            sel_q       <= sel_d;
        end
    end

    assign O_COIN_VALID = valid_q;
    assign O_COIN_SEL   = sel_q;
    assign O_BUSY       = busy_q;
    assign O_DONE       = (state_q == ST_DONE);
    assign O_SHORT      = short_q;
    assign O_COINS      = coins_q;
    assign O_FAULT      = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser with a greedy payout model and a
// hopper that acks after a random delay or withholds acks on chosen tubes.
module tb_change_dispenser;

    localparam int P_TIMEOUT = 8;
    localparam int CNT_W     = 8;

    logic             I_CLK = 1'b0;
    logic             I_RESET = 1'b1;
    logic             I_START = 1'b0;
    logic [15:0]      I_AMOUNT = 16'd0;
    logic [5:0]       I_EMPTY = 6'd0;
    logic             I_COIN_ACK = 1'b0;
    logic             O_COIN_VALID;
    logic [2:0]       O_COIN_SEL;
    logic             O_BUSY;
    logic             O_DONE;
    logic [15:0]      O_SHORT;
    logic [CNT_W-1:0] O_COINS;
    logic [5:0]       O_FAULT;

    int nChecks = 0;
    int nErrors = 0;
    logic [5:0] faultModel = 6'd0;
    int coinVal [6] = '{500, 100, 25, 10, 5, 1};

    change_dispenser #(.P_ACK_TIMEOUT(P_TIMEOUT), .P_CNT_W(CNT_W)) dut (
        .I_CLK        (I_CLK),
        .I_RESET      (I_RESET),
        .I_START      (I_START),
        .I_AMOUNT     (I_AMOUNT),
        .I_EMPTY      (I_EMPTY),
        .I_COIN_ACK   (I_COIN_ACK),
        .O_COIN_VALID (O_COIN_VALID),
        .O_COIN_SEL   (O_COIN_SEL),
        .O_BUSY       (O_BUSY),
        .O_DONE       (O_DONE),
        .O_SHORT      (O_SHORT),
        .O_COINS      (O_COINS),
        .O_FAULT      (O_FAULT)
    );

    // Free-running clock, rising edge is the active edge.
    always #5 I_CLK = ~I_CLK;

    task automatic do_reset();
        @(negedge I_CLK);
        I_RESET = 1'b1;
        I_START = 1'b0;
        I_COIN_ACK = 1'b0;
        @(negedge I_CLK);
        @(negedge I_CLK);
        I_RESET = 1'b0;
        faultModel = 6'd0;
    endtask

    // One complete transaction against the greedy model, called at a negedge.
    task automatic run_txn(input logic [15:0] amount, input logic [5:0] empty,
                           input logic [5:0] stuck, input bit ackHigh,
                           input bit poke, input string tag);
        int expSel[$];
        int gotSel[$];
        int rem, expShort, expCoins, cyc, winLen, delay, firstValid, curSel;
        bit found, anyPick, seenDone, pokeDone, prevValid, acked, ackNow;
        logic [5:0] stuckEff;

        stuckEff = ackHigh ? 6'd0 : stuck;
        rem = int'(amount);
        anyPick = 1'b0;
        if (rem > 0) begin
            do begin
                found = 1'b0;
                for (int d = 0; d < 6; d++) begin
                    if (!found && coinVal[d] <= rem && !empty[d] && !faultModel[d]) begin
                        found = 1'b1;
                        anyPick = 1'b1;
                        if (stuckEff[d]) faultModel[d] = 1'b1;
                        else begin
                            expSel.push_back(d);
                            rem -= coinVal[d];
                        end
                    end
                end
            end while (found && rem > 0);
        end
        expShort = rem;
        expCoins = (expSel.size() > 255) ? 255 : expSel.size();

        I_AMOUNT = amount;
        I_EMPTY = empty;
        I_START = 1'b1;
        I_COIN_ACK = ackHigh;
        @(negedge I_CLK);
        cyc = 1;
        seenDone = 1'b0; pokeDone = 1'b0; prevValid = 1'b0; acked = 1'b0;
        winLen = 0; delay = 0; firstValid = -1; curSel = 0;
        while (!seenDone && cyc < 6000) begin
            I_START = 1'b0;
            if (cyc == 1) begin
                nChecks++;
                if (O_BUSY !== 1'b1) begin
                    nErrors++;
                    $display("[TB] FAIL %s busy_after_start: got %b want 1", tag, O_BUSY);
                end
            end
            if (O_DONE === 1'b1) begin
                seenDone = 1'b1;
            end else begin
                if (O_COIN_VALID === 1'b1) begin
                    if (firstValid < 0) firstValid = cyc;
                    if (!prevValid) begin
                        winLen = 1;
                        curSel = int'(O_COIN_SEL);
                        acked = 1'b0;
                        delay = int'($urandom_range(0, 3));
                    end else begin
                        winLen++;
                        nChecks++;
                        if (int'(O_COIN_SEL) != curSel) begin
                            nErrors++;
                            $display("[TB] FAIL %s sel_stable: got %0d want %0d", tag, O_COIN_SEL, curSel);
                        end
                    end
                end else if (prevValid && !acked) begin
                    nChecks++;
                    if (winLen != P_TIMEOUT) begin
                        nErrors++;
                        $display("[TB] FAIL %s timeout_len: got %0d want %0d", tag, winLen, P_TIMEOUT);
                    end
                end
                ackNow = (O_COIN_VALID === 1'b1) && (ackHigh || (curSel < 6 && !stuckEff[curSel] && (winLen - 1) == delay));
                if (ackNow) begin
                    gotSel.push_back(curSel);
                    acked = 1'b1;
                end
                I_COIN_ACK = ackHigh ? 1'b1 : ackNow;
                if (poke && !pokeDone && cyc >= 3 && O_BUSY === 1'b1) begin
                    I_START = 1'b1;
                    I_AMOUNT = 16'($urandom_range(1, 900));
                    pokeDone = 1'b1;
                end
                prevValid = (O_COIN_VALID === 1'b1);
                @(negedge I_CLK);
                cyc++;
            end
        end
        I_START = 1'b0;
        I_COIN_ACK = 1'b0;

        nChecks++;
        if (!seenDone) begin
            nErrors++;
            $display("[TB] FAIL %s done_timeout: got no O_DONE after %0d cycles want pulse", tag, cyc);
        end else begin
            nChecks++;
            if (int'(O_SHORT) != expShort) begin
                nErrors++;
                $display("[TB] FAIL %s short: got %0d want %0d", tag, O_SHORT, expShort);
            end
            nChecks++;
            if (int'(O_COINS) != expCoins) begin
                nErrors++;
                $display("[TB] FAIL %s coins: got %0d want %0d", tag, O_COINS, expCoins);
            end
            nChecks++;
            if (O_FAULT !== faultModel) begin
                nErrors++;
                $display("[TB] FAIL %s fault: got %b want %b", tag, O_FAULT, faultModel);
            end
            nChecks++;
            if (gotSel.size() != expSel.size()) begin
                nErrors++;
                $display("[TB] FAIL %s coin_count_seen: got %0d want %0d", tag, gotSel.size(), expSel.size());
            end else begin
                for (int i = 0; i < expSel.size(); i++) begin
                    nChecks++;
                    if (gotSel[i] != expSel[i]) begin
                        nErrors++;
                        $display("[TB] FAIL %s sel_seq[%0d]: got %0d want %0d", tag, i, gotSel[i], expSel[i]);
                    end
                end
            end
            nChecks++;
            if (firstValid != (anyPick ? 2 : -1)) begin
                nErrors++;
                $display("[TB] FAIL %s first_valid_cycle: got %0d want %0d", tag, firstValid, anyPick ? 2 : -1);
            end
            if (amount == 16'd0) begin
                nChecks++;
                if (cyc != 1) begin
                    nErrors++;
                    $display("[TB] FAIL %s zero_done_latency: got %0d want 1", tag, cyc);
                end
            end
        end
        @(negedge I_CLK);
        nChecks++;
        if (O_BUSY !== 1'b0 || O_DONE !== 1'b0 || int'(O_SHORT) != expShort) begin
            nErrors++;
            $display("[TB] FAIL %s after_done: got busy=%b done=%b short=%0d want 0 0 %0d",
                     tag, O_BUSY, O_DONE, O_SHORT, expShort);
        end
    endtask

    task automatic test_reset();
        do_reset();
        nChecks++;
        if (O_COIN_VALID !== 1'b0 || O_COIN_SEL !== 3'd0 || O_BUSY !== 1'b0 || O_DONE !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL reset_ctrl: got v=%b s=%0d b=%b d=%b want 0 0 0 0",
                     O_COIN_VALID, O_COIN_SEL, O_BUSY, O_DONE);
        end
        nChecks++;
        if (O_SHORT !== 16'd0 || O_COINS !== 8'd0 || O_FAULT !== 6'd0) begin
            nErrors++;
            $display("[TB] FAIL reset_data: got short=%0d coins=%0d fault=%b want 0 0 0",
                     O_SHORT, O_COINS, O_FAULT);
        end
    endtask

    task automatic test_basic();
        run_txn(16'd200, 6'd0, 6'd0, 1'b0, 1'b0, "amt200");
        nChecks++;
        if (O_COINS !== 8'd2) begin
            nErrors++;
            $display("[TB] FAIL amt200_const_coins: got %0d want 2", O_COINS);
        end
        run_txn(16'd0, 6'd0, 6'd0, 1'b0, 1'b0, "amt0");
        run_txn(16'd41, 6'b000100, 6'd0, 1'b0, 1'b0, "amt41");
        nChecks++;
        if (O_COINS !== 8'd5) begin
            nErrors++;
            $display("[TB] FAIL amt41_const_coins: got %0d want 5", O_COINS);
        end
        run_txn(16'd3, 6'b100000, 6'd0, 1'b0, 1'b0, "amt3");
        nChecks++;
        if (O_SHORT !== 16'd3) begin
            nErrors++;
            $display("[TB] FAIL amt3_const_short: got %0d want 3", O_SHORT);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run_txn(16'd150, 6'd0, 6'b000010, 1'b0, 1'b0, "to150");
        nChecks++;
        if (O_FAULT !== 6'b000010 || O_COINS !== 8'd6) begin
            nErrors++;
            $display("[TB] FAIL to150_const: got fault=%b coins=%0d want 000010 6", O_FAULT, O_COINS);
        end
        run_txn(16'd100, 6'd0, 6'd0, 1'b0, 1'b0, "to100");
        nChecks++;
        if (O_COINS !== 8'd4) begin
            nErrors++;
            $display("[TB] FAIL to100_const_coins: got %0d want 4", O_COINS);
        end
    endtask

    task automatic test_reset_mid();
        int waitCnt;
        bit sawDone;
        do_reset();
        I_AMOUNT = 16'd500;
        I_EMPTY = 6'd0;
        I_START = 1'b1;
        @(negedge I_CLK);
        I_START = 1'b0;
        waitCnt = 0;
        while (O_COIN_VALID !== 1'b1 && waitCnt < 10) begin
            @(negedge I_CLK);
            waitCnt++;
        end
        @(negedge I_CLK);
        @(negedge I_CLK);
        nChecks++;
        if (O_COIN_VALID !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL rstmid_wait_ack: got valid=%b want 1", O_COIN_VALID);
        end
        I_RESET = 1'b1;
        @(negedge I_CLK);
        nChecks++;
        if (O_COIN_VALID !== 1'b0 || O_BUSY !== 1'b0 || O_FAULT !== 6'd0 || O_DONE !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL rstmid_outputs: got v=%b b=%b f=%b d=%b want 0 0 0 0",
                     O_COIN_VALID, O_BUSY, O_FAULT, O_DONE);
        end
        I_RESET = 1'b0;
        faultModel = 6'd0;
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge I_CLK);
            if (O_DONE === 1'b1 || O_COIN_VALID === 1'b1) sawDone = 1'b1;
        end
        nChecks++;
        if (sawDone) begin
            nErrors++;
            $display("[TB] FAIL rstmid_quiet: got activity after abort want none");
        end
    endtask

    task automatic test_back_to_back();
        run_txn(16'd37, 6'd0, 6'd0, 1'b1, 1'b1, "ackhigh37");
        run_txn(16'd666, 6'd0, 6'd0, 1'b0, 1'b1, "poke666");
        run_txn(16'd300, 6'b011111, 6'd0, 1'b1, 1'b0, "saturate");
        nChecks++;
        if (O_COINS !== 8'hFF) begin
            nErrors++;
            $display("[TB] FAIL saturate_const: got %0d want 255", O_COINS);
        end
    endtask

    task automatic test_random();
        logic [15:0] amt;
        logic [5:0] emp, stk;
        bit ah, pk;
        for (int n = 0; n < 16; n++) begin
            if (n % 4 == 0) do_reset();
            amt = 16'($urandom_range(0, 700));
            emp = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            stk = ($urandom_range(0, 3) == 0) ? (6'b000001 << $urandom_range(0, 5)) : 6'd0;
            ah = ($urandom_range(0, 3) == 0);
            pk = ($urandom_range(0, 1) == 1);
            run_txn(amt, emp, stk, ah, pk, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
